// File: rtl/rob_commit_ctrl_pkg.sv
// Shared widths, sizes and tag/index helpers for the in-order commit controller.
package rob_commit_ctrl_pkg;
  localparam int ROB_SIZE = 16;
  localparam int IDX_W    = 4;
  localparam int TAG_W    = 5;
  localparam int DATA_W   = 32;
  localparam int REG_W    = 5;

  typedef logic [TAG_W-1:0]  tag_t;
  typedef logic [IDX_W-1:0]  idx_t;
  typedef logic [IDX_W:0]    cnt_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [REG_W-1:0]  reg_t;

  // Tag 0 means "value lives in the regfile"; it is never handed out.
  localparam tag_t EMPTY_TAG = '0;

  function automatic idx_t tag_to_idx(input tag_t t);
    tag_t m;
    m = t - tag_t'(1);
    return m[IDX_W-1:0];
  endfunction

  function automatic tag_t idx_to_tag(input idx_t i);
    return tag_t'(i) + tag_t'(1);
  endfunction
endpackage

// File: rtl/rob_commit_ctrl_if.sv
// Decoder/CDB/regfile-facing signal bundle of the reorder buffer.
interface rob_commit_ctrl_if;
  import rob_commit_ctrl_pkg::*;

  logic  alloc_valid;
  reg_t  alloc_rd;
  tag_t  alloc_tag;
  logic  rob_full;

  logic  cdb_valid;
  tag_t  cdb_tag;
  data_t cdb_data;
  logic  cdb_mispredict;
  data_t cdb_target;

  tag_t  query_tag1;
  tag_t  query_tag2;
  logic  query_rdy1;
  logic  query_rdy2;
  data_t query_data1;
  data_t query_data2;

  logic  if_commit;
  reg_t  pos_commit;
  data_t data_commit;
  tag_t  tag_commit;
  logic  clear;
  data_t clear_pc;

  modport slave (
    input  alloc_valid, alloc_rd, cdb_valid, cdb_tag, cdb_data, cdb_mispredict, cdb_target,
           query_tag1, query_tag2,
    output alloc_tag, rob_full, query_rdy1, query_rdy2, query_data1, query_data2,
           if_commit, pos_commit, data_commit, tag_commit, clear, clear_pc
  );

  modport master (
    output alloc_valid, alloc_rd, cdb_valid, cdb_tag, cdb_data, cdb_mispredict, cdb_target,
           query_tag1, query_tag2,
    input  alloc_tag, rob_full, query_rdy1, query_rdy2, query_data1, query_data2,
           if_commit, pos_commit, data_commit, tag_commit, clear, clear_pc
  );
endinterface

// File: rtl/rob_commit_ctrl.sv
// Circular reorder buffer: allocates tags, collects CDB results, retires the head in order.
// Commit/clear outputs registered one edge after the head is ready; rdy low freezes all state.
module rob_commit_ctrl
  import rob_commit_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  rob_commit_ctrl_if.slave bus
);

  logic  ent_valid  [ROB_SIZE];
  logic  ent_ready  [ROB_SIZE];
  reg_t  ent_rd     [ROB_SIZE];
  data_t ent_data   [ROB_SIZE];
  logic  ent_mp     [ROB_SIZE];
  data_t ent_target [ROB_SIZE];

  idx_t  head;
  idx_t  tail;
  cnt_t  count;

  logic  if_commit_q;
  reg_t  pos_q;
  data_t data_q;
  tag_t  tag_q;
  logic  clear_q;
  data_t clear_pc_q;

  logic  full;
  logic  do_alloc;
  logic  do_commit;
  logic  do_wb;
  logic  flush;
  idx_t  wb_idx;
  idx_t  q1_idx;
  idx_t  q2_idx;

  // Fullness uses the pre-commit count, so a slot freed this edge is not reused until the next.
  assign full      = (count == cnt_t'(ROB_SIZE));
  assign wb_idx    = tag_to_idx(bus.cdb_tag);
  assign do_alloc  = bus.alloc_valid && !full && !clear_q;
  assign do_commit = !clear_q && ent_valid[head] && ent_ready[head];
  assign do_wb     = !clear_q && bus.cdb_valid && (bus.cdb_tag != EMPTY_TAG) && ent_valid[wb_idx];
  assign flush     = do_commit && ent_mp[head];

  always_ff @(posedge clk) begin
    if (rst) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      if_commit_q <= 1'b0;
      pos_q       <= '0;
      data_q      <= '0;
      tag_q       <= '0;
      clear_q     <= 1'b0;
      clear_pc_q  <= '0;
      for (int i = 0; i < ROB_SIZE; i++) begin
        ent_valid[i]  <= 1'b0;
        ent_ready[i]  <= 1'b0;
        ent_rd[i]     <= '0;
        ent_data[i]   <= '0;
        ent_mp[i]     <= 1'b0;
        ent_target[i] <= '0;
      end
    end else if (rdy) begin
      clear_q <= flush;
      if (flush) clear_pc_q <= ent_target[head];

      if (do_commit) begin
        if_commit_q <= (ent_rd[head] != '0);
        pos_q       <= ent_rd[head];
        data_q      <= ent_data[head];
        tag_q       <= idx_to_tag(head);
      end else begin
        if_commit_q <= 1'b0;
      end

      if (flush) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
        for (int i = 0; i < ROB_SIZE; i++) begin
          ent_valid[i] <= 1'b0;
          ent_ready[i] <= 1'b0;
        end
      end else begin
        if (do_wb) begin
          ent_ready[wb_idx]  <= 1'b1;
          ent_data[wb_idx]   <= bus.cdb_data;
          ent_mp[wb_idx]     <= bus.cdb_mispredict;
          ent_target[wb_idx] <= bus.cdb_target;
        end
        if (do_commit) begin
          ent_valid[head] <= 1'b0;
          ent_ready[head] <= 1'b0;
          head            <= head + idx_t'(1);
        end
        // Placed last so an allocation overrides a stray writeback to the same slot.
        if (do_alloc) begin
          ent_valid[tail] <= 1'b1;
          ent_ready[tail] <= 1'b0;
          ent_rd[tail]    <= bus.alloc_rd;
          ent_mp[tail]    <= 1'b0;
          tail            <= tail + idx_t'(1);
        end
        if (do_alloc && !do_commit)      count <= count + cnt_t'(1);
        else if (!do_alloc && do_commit) count <= count - cnt_t'(1);
      end
    end
  end

  assign q1_idx = tag_to_idx(bus.query_tag1);
  assign q2_idx = tag_to_idx(bus.query_tag2);

  always_comb begin
    bus.query_rdy1  = 1'b0;
    bus.query_data1 = '0;
    bus.query_rdy2  = 1'b0;
    bus.query_data2 = '0;
    if (bus.cdb_valid && bus.query_tag1 != EMPTY_TAG && bus.cdb_tag == bus.query_tag1) begin
      bus.query_rdy1  = 1'b1;
      bus.query_data1 = bus.cdb_data;
    end else if (bus.query_tag1 != EMPTY_TAG && ent_valid[q1_idx] && ent_ready[q1_idx]) begin
      bus.query_rdy1  = 1'b1;
      bus.query_data1 = ent_data[q1_idx];
    end
    if (bus.cdb_valid && bus.query_tag2 != EMPTY_TAG && bus.cdb_tag == bus.query_tag2) begin
      bus.query_rdy2  = 1'b1;
      bus.query_data2 = bus.cdb_data;
    end else if (bus.query_tag2 != EMPTY_TAG && ent_valid[q2_idx] && ent_ready[q2_idx]) begin
      bus.query_rdy2  = 1'b1;
      bus.query_data2 = ent_data[q2_idx];
    end
  end

  assign bus.alloc_tag   = idx_to_tag(tail);
  assign bus.rob_full    = full;
  assign bus.if_commit   = if_commit_q;
  assign bus.pos_commit  = pos_q;
  assign bus.data_commit = data_q;
  assign bus.tag_commit  = tag_q;
  assign bus.clear       = clear_q;
  assign bus.clear_pc    = clear_pc_q;

endmodule

// File: tb/tb_rob_commit_ctrl.sv
// Directed bench for rob_commit_ctrl: hand-computed expectations checked with immediate assertions.
module tb_rob_commit_ctrl;
  logic clk;
  logic rst;
  logic rdy;
  int   checks;
  int   failures;

  rob_commit_ctrl_if bus ();

  rob_commit_ctrl dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.alloc_valid    = 1'b0;
    bus.alloc_rd       = '0;
    bus.cdb_valid      = 1'b0;
    bus.cdb_tag        = '0;
    bus.cdb_data       = '0;
    bus.cdb_mispredict = 1'b0;
    bus.cdb_target     = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic alloc(input logic [4:0] rd);
    bus.alloc_valid = 1'b1;
    bus.alloc_rd    = rd;
    tick();
    bus.alloc_valid = 1'b0;
  endtask

  task automatic cdb(input logic [4:0] tag, input logic [31:0] data);
    bus.cdb_valid = 1'b1;
    bus.cdb_tag   = tag;
    bus.cdb_data  = data;
    tick();
    bus.cdb_valid = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rdy      = 1'b1;
    bus.query_tag1 = '0;
    bus.query_tag2 = '0;
    do_reset();
    tick();

    chk("rst_if_commit", 32'(bus.if_commit), 32'd0);
    chk("rst_clear", 32'(bus.clear), 32'd0);
    chk("rst_clear_pc", bus.clear_pc, 32'd0);
    chk("rst_pos", 32'(bus.pos_commit), 32'd0);
    chk("rst_tag_commit", 32'(bus.tag_commit), 32'd0);
    chk("rst_full", 32'(bus.rob_full), 32'd0);
    chk("rst_alloc_tag", 32'(bus.alloc_tag), 32'd1);

    // Single alloc, writeback, commit two edges after the CDB.
    alloc(5'd5);
    chk("t1_alloc_tag", 32'(bus.alloc_tag), 32'd2);
    cdb(5'd1, 32'hABCD);
    chk("t1_no_early_commit", 32'(bus.if_commit), 32'd0);
    tick();
    chk("t1_if_commit", 32'(bus.if_commit), 32'd1);
    chk("t1_pos", 32'(bus.pos_commit), 32'd5);
    chk("t1_data", bus.data_commit, 32'hABCD);
    chk("t1_tag", 32'(bus.tag_commit), 32'd1);
    tick();
    chk("t1_pulse_end", 32'(bus.if_commit), 32'd0);

    // Out-of-order writeback, in-order commit.
    do_reset();
    alloc(5'd3);
    alloc(5'd4);
    cdb(5'd2, 32'h44);
    tick();
    chk("t2_wait_head_a", 32'(bus.if_commit), 32'd0);
    tick();
    chk("t2_wait_head_b", 32'(bus.if_commit), 32'd0);
    cdb(5'd1, 32'h33);
    chk("t2_wait_head_c", 32'(bus.if_commit), 32'd0);
    tick();
    chk("t2_c1_pos", 32'(bus.pos_commit), 32'd3);
    chk("t2_c1_data", bus.data_commit, 32'h33);
    chk("t2_c1_valid", 32'(bus.if_commit), 32'd1);
    tick();
    chk("t2_c2_pos", 32'(bus.pos_commit), 32'd4);
    chk("t2_c2_tag", 32'(bus.tag_commit), 32'd2);
    chk("t2_c2_valid", 32'(bus.if_commit), 32'd1);
    tick();
    chk("t2_idle", 32'(bus.if_commit), 32'd0);

    // Fill to capacity, overflow alloc, then commit-and-alloc at the full boundary.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      bus.alloc_valid = 1'b1;
      bus.alloc_rd    = 5'(i + 1);
      #1;
      chk("t3_fill_tag", 32'(bus.alloc_tag), 32'(i + 1));
      tick();
    end
    bus.alloc_valid = 1'b0;
    chk("t3_full", 32'(bus.rob_full), 32'd1);
    alloc(5'd20);
    chk("t3_overflow_full", 32'(bus.rob_full), 32'd1);
    chk("t3_overflow_tag", 32'(bus.alloc_tag), 32'd1);
    cdb(5'd1, 32'h11);
    bus.alloc_valid = 1'b1;
    bus.alloc_rd    = 5'd21;
    #1;
    chk("t3_full_precommit", 32'(bus.rob_full), 32'd1);
    tick();
    chk("t3_commit_valid", 32'(bus.if_commit), 32'd1);
    chk("t3_commit_tag", 32'(bus.tag_commit), 32'd1);
    chk("t3_commit_data", bus.data_commit, 32'h11);
    chk("t3_after_commit_full", 32'(bus.rob_full), 32'd0);
    chk("t3_wrap_tag", 32'(bus.alloc_tag), 32'd1);
    tick();
    bus.alloc_valid = 1'b0;
    chk("t3_refull", 32'(bus.rob_full), 32'd1);
    chk("t3_tail_adv", 32'(bus.alloc_tag), 32'd2);

    // Mispredict at head: commit plus one-cycle clear, later inputs ignored.
    do_reset();
    alloc(5'd1);
    alloc(5'd2);
    alloc(5'd3);
    bus.cdb_mispredict = 1'b1;
    bus.cdb_target     = 32'h100;
    cdb(5'd1, 32'h1004);
    bus.cdb_mispredict = 1'b0;
    chk("t4_no_clear_yet", 32'(bus.clear), 32'd0);
    tick();
    chk("t4_clear", 32'(bus.clear), 32'd1);
    chk("t4_clear_pc", bus.clear_pc, 32'h100);
    chk("t4_link_commit", 32'(bus.if_commit), 32'd1);
    chk("t4_link_data", bus.data_commit, 32'h1004);
    chk("t4_link_tag", 32'(bus.tag_commit), 32'd1);
    chk("t4_tag_reset", 32'(bus.alloc_tag), 32'd1);
    bus.alloc_valid = 1'b1;
    bus.alloc_rd    = 5'd9;
    cdb(5'd2, 32'h22);
    bus.alloc_valid = 1'b0;
    chk("t4_clear_drop", 32'(bus.clear), 32'd0);
    chk("t4_commit_drop", 32'(bus.if_commit), 32'd0);
    chk("t4_alloc_ignored", 32'(bus.alloc_tag), 32'd1);
    alloc(5'd7);
    tick();
    bus.query_tag1 = 5'd2;
    #1;
    chk("t4_cdb_ignored", 32'(bus.query_rdy1), 32'd0);
    chk("t4_no_commit", 32'(bus.if_commit), 32'd0);
    bus.query_tag1 = '0;

    // rd=0 retires silently; the next entry commits on the following cycle.
    do_reset();
    alloc(5'd0);
    alloc(5'd6);
    cdb(5'd1, 32'h55);
    cdb(5'd2, 32'h66);
    chk("t5_rd0_silent", 32'(bus.if_commit), 32'd0);
    tick();
    chk("t5_next_valid", 32'(bus.if_commit), 32'd1);
    chk("t5_next_pos", 32'(bus.pos_commit), 32'd6);
    chk("t5_next_data", bus.data_commit, 32'h66);
    chk("t5_next_tag", 32'(bus.tag_commit), 32'd2);

    // CDB bypass on query, then a three-cycle stall.
    do_reset();
    alloc(5'd8);
    alloc(5'd9);
    bus.query_tag1 = 5'd2;
    bus.query_tag2 = 5'd1;
    bus.cdb_valid  = 1'b1;
    bus.cdb_tag    = 5'd2;
    bus.cdb_data   = 32'd7;
    #1;
    chk("t6_bypass_rdy", 32'(bus.query_rdy1), 32'd1);
    chk("t6_bypass_data", bus.query_data1, 32'd7);
    chk("t6_other_notrdy", 32'(bus.query_rdy2), 32'd0);
    tick();
    bus.cdb_valid = 1'b0;
    #1;
    chk("t6_stored_rdy", 32'(bus.query_rdy1), 32'd1);
    chk("t6_stored_data", bus.query_data1, 32'd7);
    cdb(5'd1, 32'h80);
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_stall_commit", 32'(bus.if_commit), 32'd0);
    end
    chk("t6_stall_query", bus.query_data2, 32'h80);
    chk("t6_stall_tail", 32'(bus.alloc_tag), 32'd3);
    rdy = 1'b1;
    tick();
    chk("t6_c1_valid", 32'(bus.if_commit), 32'd1);
    chk("t6_c1_pos", 32'(bus.pos_commit), 32'd8);
    chk("t6_c1_tag", 32'(bus.tag_commit), 32'd1);
    tick();
    chk("t6_c2_pos", 32'(bus.pos_commit), 32'd9);
    chk("t6_c2_data", bus.data_commit, 32'd7);
    tick();
    chk("t6_idle", 32'(bus.if_commit), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
